// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/status bundle between the core datapath and the PC sequencer.
// master = control/ALU side driving requests, slave = the sequencer.
interface pc_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int CAUSE_W = 4
);
    logic               PCS_load;
    logic [PC_W-1:0]    PCS_load_val;
    logic               PCS_stall;
    logic               PCS_branch_taken;
    logic [PC_W-1:0]    PCS_branch_off;
    logic               PCS_jump;
    logic [PC_W-1:0]    PCS_jump_target;
    logic               PCS_eret;
    logic               PCS_exc_req;
    logic [CAUSE_W-1:0] PCS_exc_cause;
    logic [PC_W-1:0]    PCS_pc;
    logic [PC_W-1:0]    PCS_epc;
    logic [CAUSE_W-1:0] PCS_cause;
    logic               PCS_exl;
    logic               PCS_valid;
    logic               PCS_kill;
    logic [1:0]         PCS_state;
    logic [31:0]        PCS_retired;

    modport master (
        output PCS_load, PCS_load_val, PCS_stall, PCS_branch_taken, PCS_branch_off,
               PCS_jump, PCS_jump_target, PCS_eret, PCS_exc_req, PCS_exc_cause,
        input  PCS_pc, PCS_epc, PCS_cause, PCS_exl, PCS_valid, PCS_kill,
               PCS_state, PCS_retired
    );

    modport slave (
        input  PCS_load, PCS_load_val, PCS_stall, PCS_branch_taken, PCS_branch_off,
               PCS_jump, PCS_jump_target, PCS_eret, PCS_exc_req, PCS_exc_cause,
        output PCS_pc, PCS_epc, PCS_cause, PCS_exl, PCS_valid, PCS_kill,
               PCS_state, PCS_retired
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, EPC/cause capture, nested-exception halt,
// exception return and a one-cycle trap-dispatch bubble.
// Optional feature macro: PCS_RETIRE_CNT_EN builds a 32-bit retired-instruction
// counter; without it PCS_retired is tied to zero.
module pc_sequencer #(
    parameter int              PC_W        = 8,
    parameter int              INSTR_BYTES = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [PC_W-1:0] EXC_VECTOR  = PC_W'('h80),
    parameter int              CAUSE_W     = 4
) (
    input  logic          SYS_clk,
    input  logic          SYS_reset_n,
    pc_sequencer_if.slave pcs
);
    localparam int SH = $clog2(INSTR_BYTES);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_TRAP = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    epc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic               exl_q;

    logic               valid;
    logic               kill;
    logic [PC_W-1:0]    seq_pc_d;
    logic [PC_W-1:0]    br_pc_d;

    // Only RUN presents an executable instruction; a faulting one is killed in-cycle.
    assign valid    = (state_q == S_RUN);
    assign kill     = valid & pcs.PCS_exc_req;
    // Branch offset counts instructions, so scale it to bytes; all sums wrap at PC_W.
    assign seq_pc_d = pc_q + PC_W'(INSTR_BYTES);
    assign br_pc_d  = seq_pc_d + (pcs.PCS_branch_off << SH);

    // Sequencer FSM: load overrides everything in every state, then per-state rules.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            cause_q <= '0;
            exl_q   <= 1'b0;
        end else if (pcs.PCS_load) begin
            pc_q    <= pcs.PCS_load_val;
            exl_q   <= 1'b0;
            state_q <= S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (pcs.PCS_exc_req && !exl_q) begin
                        epc_q   <= pc_q;
                        cause_q <= pcs.PCS_exc_cause;
                        exl_q   <= 1'b1;
                        pc_q    <= EXC_VECTOR;
                        state_q <= S_TRAP;
                    end else if (pcs.PCS_exc_req) begin
                        // Fault inside the handler: record why and freeze.
                        cause_q <= pcs.PCS_exc_cause;
                        state_q <= S_HALT;
                    end else if (pcs.PCS_stall) begin
                        pc_q <= pc_q;
                    end else if (pcs.PCS_eret && exl_q) begin
                        pc_q  <= epc_q;
                        exl_q <= 1'b0;
                    end else if (pcs.PCS_jump) begin
                        pc_q <= pcs.PCS_jump_target;
                    end else if (pcs.PCS_branch_taken) begin
                        pc_q <= br_pc_d;
                    end else begin
                        pc_q <= seq_pc_d;
                    end
                end
                // Flush bubble: vector is fetched but not executed this cycle.
                S_TRAP:  state_q <= S_RUN;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_RUN;
            endcase
        end
    end

`ifdef PCS_RETIRE_CNT_EN
    logic [31:0] retired_q;
    logic        retire;

    assign retire = valid & ~pcs.PCS_stall & ~kill;

    // Retired-instruction counter; wraps silently and is untouched by load.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n)
            retired_q <= '0;
        else if (retire)
            retired_q <= retired_q + 32'd1;
    end

    assign pcs.PCS_retired = retired_q;
`else
    assign pcs.PCS_retired = '0;
`endif

    assign pcs.PCS_pc    = pc_q;
    assign pcs.PCS_epc   = epc_q;
    assign pcs.PCS_cause = cause_q;
    assign pcs.PCS_exl   = exl_q;
    assign pcs.PCS_valid = valid;
    assign pcs.PCS_kill  = kill;
    assign pcs.PCS_state = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan sequences plus randomized traffic.
// Driver steps a behavioural model and pushes expectations; a monitor pops and compares.
module tb_pc_sequencer;
    logic SYS_clk;
    logic SYS_reset_n;

    pc_sequencer_if #(.PC_W(8), .CAUSE_W(4)) bus ();

    pc_sequencer #(
        .PC_W(8), .INSTR_BYTES(4), .RESET_PC(8'h00), .EXC_VECTOR(8'h80), .CAUSE_W(4)
    ) dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset_n (SYS_reset_n),
        .pcs         (bus)
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    typedef struct {
        bit          kill;
        int          pc;
        int          epc;
        int          cause;
        int          exl;
        int          st;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state (0=RUN 1=TRAP 2=HALT)
    int          m_pc, m_epc, m_cause, m_exl, m_st;
    logic [31:0] m_ret;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_epc = 0; m_cause = 0; m_exl = 0; m_st = 0; m_ret = 0;
    endtask

    // Drive one cycle at a negedge, advance the model, queue expectations, wait for next negedge.
    task automatic step(input bit ld, input logic [7:0] ldv, input bit st, input bit br,
                        input logic [7:0] off, input bit jp, input logic [7:0] tgt,
                        input bit er, input bit ex, input logic [3:0] cs);
        exp_t e;
        bit   valid, kill, retire;
        int   so;
        bus.PCS_load = ld;       bus.PCS_load_val = ldv;
        bus.PCS_stall = st;      bus.PCS_branch_taken = br;
        bus.PCS_branch_off = off; bus.PCS_jump = jp;
        bus.PCS_jump_target = tgt; bus.PCS_eret = er;
        bus.PCS_exc_req = ex;    bus.PCS_exc_cause = cs;
        valid  = (m_st == 0);
        kill   = valid && ex;
        retire = valid && !st && !kill;
        so     = $signed(off);
        if (ld) begin
            m_pc = ldv; m_exl = 0; m_st = 0;
        end else if (m_st == 1) begin
            m_st = 0;
        end else if (m_st == 2) begin
            m_st = 2;
        end else if (ex && m_exl == 0) begin
            m_epc = m_pc; m_cause = cs; m_exl = 1; m_pc = 'h80; m_st = 1;
        end else if (ex) begin
            m_cause = cs; m_st = 2;
        end else if (st) begin
            m_pc = m_pc;
        end else if (er && m_exl == 1) begin
            m_pc = m_epc; m_exl = 0;
        end else if (jp) begin
            m_pc = tgt;
        end else if (br) begin
            m_pc = (m_pc + 4 + 4 * so) & 255;
        end else begin
            m_pc = (m_pc + 4) & 255;
        end
`ifdef PCS_RETIRE_CNT_EN
        if (retire) m_ret = m_ret + 32'd1;
`endif
        e.kill = kill; e.pc = m_pc; e.epc = m_epc; e.cause = m_cause;
        e.exl = m_exl; e.st = m_st; e.ret = m_ret;
        q.push_back(e);
        @(negedge SYS_clk);
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0);
    endtask

    task automatic load(input logic [7:0] v);
        step(1, v, 0, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0);
    endtask

    // Monitor: kill is checked mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge SYS_clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("kill", 32'(bus.PCS_kill), 32'(e.kill));
                @(posedge SYS_clk);
                #1;
                chk("pc",      32'(bus.PCS_pc),    32'(e.pc));
                chk("epc",     32'(bus.PCS_epc),   32'(e.epc));
                chk("cause",   32'(bus.PCS_cause), 32'(e.cause));
                chk("exl",     32'(bus.PCS_exl),   32'(e.exl));
                chk("state",   32'(bus.PCS_state), 32'(e.st));
                chk("valid",   32'(bus.PCS_valid), 32'(e.st == 0));
                chk("retired", bus.PCS_retired,    e.ret);
            end
        end
    end

    initial begin
        logic [31:0] exp_ret7;
        bit ld, st, br, jp, er, ex;
        int r;
`ifdef PCS_RETIRE_CNT_EN
        exp_ret7 = 32'd7;
`else
        exp_ret7 = 32'd0;
`endif
        SYS_reset_n = 1'b0;
        bus.PCS_load = 0; bus.PCS_load_val = 0; bus.PCS_stall = 0;
        bus.PCS_branch_taken = 0; bus.PCS_branch_off = 0; bus.PCS_jump = 0;
        bus.PCS_jump_target = 0; bus.PCS_eret = 0; bus.PCS_exc_req = 0;
        bus.PCS_exc_cause = 0;
        model_reset();
        @(negedge SYS_clk);
        @(negedge SYS_clk);
        chk("rst_pc",    32'(bus.PCS_pc),    32'h00);
        chk("rst_epc",   32'(bus.PCS_epc),   32'h00);
        chk("rst_cause", 32'(bus.PCS_cause), 32'h0);
        chk("rst_exl",   32'(bus.PCS_exl),   32'h0);
        chk("rst_state", 32'(bus.PCS_state), 32'h0);
        chk("rst_ret",   bus.PCS_retired,    32'h0);
        SYS_reset_n = 1'b1;

        // reset and run
        idle(); idle(); idle();
        chk("run3_pc", 32'(bus.PCS_pc), 32'h0C);

        // asynchronous reset between edges
        SYS_reset_n = 1'b0;
        #1;
        chk("async_rst_pc",  32'(bus.PCS_pc), 32'h00);
        chk("async_rst_ret", bus.PCS_retired, 32'h0);
        @(negedge SYS_clk);
        SYS_reset_n = 1'b1;
        model_reset();

        // counter: 7 sequential, 2 stalled, 1 killed
        repeat (7) idle();
        step(0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0);
        step(0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0);
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 4'h3);
        chk("cnt_retired", bus.PCS_retired,    exp_ret7);
        chk("trap_state",  32'(bus.PCS_state), 32'h1);
        chk("trap_pc",     32'(bus.PCS_pc),    32'h80);
        chk("trap_epc",    32'(bus.PCS_epc),   32'h1C);
        idle();
        chk("handler_valid", 32'(bus.PCS_valid), 32'h1);
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1, 0, 4'h0);
        chk("eret_pc", 32'(bus.PCS_pc), 32'h1C);

        // branch back, wrap, jump
        load(8'h10);
        step(0, 8'h00, 0, 1, 8'hFE, 0, 8'h00, 0, 0, 4'h0);
        chk("br_neg_pc", 32'(bus.PCS_pc), 32'h0C);
        load(8'hFC);
        idle();
        chk("wrap_pc", 32'(bus.PCS_pc), 32'h00);
        load(8'h30);
        step(0, 8'h00, 0, 0, 8'h00, 1, 8'h44, 0, 0, 4'h0);
        chk("jump_pc", 32'(bus.PCS_pc), 32'h44);

        // exception at 0x20 then double fault
        load(8'h20);
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 4'h3);
        chk("exc_epc", 32'(bus.PCS_epc), 32'h20);
        idle();
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 4'h5);
        chk("df_state", 32'(bus.PCS_state), 32'h2);
        chk("df_cause", 32'(bus.PCS_cause), 32'h5);
        step(0, 8'h00, 0, 1, 8'h05, 1, 8'h12, 1, 1, 4'h7);
        chk("halt_pc", 32'(bus.PCS_pc), 32'h80);
        load(8'h40);
        chk("df_load_pc",  32'(bus.PCS_pc),  32'h40);
        chk("df_load_exl", 32'(bus.PCS_exl), 32'h0);

        // stall+exc -> trap; load+exc -> load only
        step(0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 4'h2);
        chk("stall_exc_state", 32'(bus.PCS_state), 32'h1);
        idle();
        step(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1, 0, 4'h0);
        step(1, 8'h50, 0, 0, 8'h00, 0, 8'h00, 0, 1, 4'h9);
        chk("load_exc_state", 32'(bus.PCS_state), 32'h0);
        chk("load_exc_pc",    32'(bus.PCS_pc),    32'h50);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(99) < 5);
            st = ($urandom_range(99) < 15);
            ex = ($urandom_range(99) < 8);
            r  = $urandom_range(99);
            jp = (r < 10);
            br = (r >= 10 && r < 25);
            er = (r >= 25 && r < 40);
            step(ld, 8'($urandom), st, br, 8'($urandom), jp, 8'($urandom), er, ex,
                 4'($urandom));
        end

        repeat (3) @(negedge SYS_clk);
        chk("sb_drain", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
